// File: rtl/vp_pkg.sv
// Shared types and defaults for the vector memory sequencer: FSM state
// encoding, default geometry, and the load/store direction encoding.
package vp_pkg;

  localparam int VLEN_DEF = 8;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 8;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WB,
    S_FIN
  } state_t;

endpackage

// File: rtl/vmem_seq_if.sv
// Memory and vector-register-file bus driven by the sequencer (master)
// and served by the memory / vector RF (slave).
interface vmem_seq_if #(
  parameter int VLEN = 8,
  parameter int DW   = 8,
  parameter int AW   = 8
);
  localparam int EW = $clog2(VLEN);

  logic [2:0]    vreg_idx;
  logic [EW-1:0] vreg_elem;
  logic          vreg_we;
  logic [DW-1:0] vreg_wdata;
  logic [DW-1:0] vreg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output vreg_idx, vreg_elem, vreg_we, vreg_wdata, mem_addr, mem_re, mem_we, mem_wdata,
    input  vreg_rdata, mem_rdata
  );

  modport slave (
    input  vreg_idx, vreg_elem, vreg_we, vreg_wdata, mem_addr, mem_re, mem_we, mem_wdata,
    output vreg_rdata, mem_rdata
  );
endinterface

// File: rtl/vmem_addr_gen.sv
// Incremental address accumulator (base + i*step, wrapping mod 2^AW)
// and element counter for one vector access.
module vmem_addr_gen
  import vp_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int EW   = $clog2(VLEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          advance,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] step,
  output logic [AW-1:0] addr,
  output logic [EW-1:0] elem,
  output logic          last
);

  logic [AW-1:0] step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      step_q <= '0;
      elem   <= '0;
    end else if (init) begin
      addr   <= base;
      step_q <= step;
      elem   <= '0;
    end else if (advance) begin
      addr <= addr + step_q;
      elem <= elem + EW'(1);
    end
  end

  assign last = (elem == EW'(VLEN - 1));

endmodule

// File: rtl/vmem_seq.sv
// Vector load/store sequencer: walks VLEN elements, one memory access each.
// Define VMEM_MASK_EN to honour mask_enable/mask; otherwise every element is accessed.
module vmem_seq
  import vp_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            rw,
  input  logic            stride_enable,
  input  logic            mask_enable,
  input  logic [2:0]      vx_select,
  input  logic [2:0]      rx_select,
  input  logic [2:0]      ry_select,
  output logic [2:0]      sreg_raddr_a,
  output logic [2:0]      sreg_raddr_b,
  input  logic [AW-1:0]   sreg_rdata_a,
  input  logic [AW-1:0]   sreg_rdata_b,
  input  logic [VLEN-1:0] mask,
  output logic            busy,
  output logic            done,
  vmem_seq_if.master      bus
);

  localparam int EW = $clog2(VLEN);

`ifdef VMEM_MASK_EN
  localparam logic MASK_FEATURE = 1'b1;
`else
  localparam logic MASK_FEATURE = 1'b0;
`endif

  state_t state, nstate;

  logic            rw_q, se_q, me_q;
  logic [2:0]      vx_q, rx_q, ry_q;
  logic [VLEN-1:0] mask_q;
  logic            init, advance, last, elem_en;
  logic            mem_re, mem_we, vreg_we;
  logic [AW-1:0]   addr;
  logic [EW-1:0]   elem;

  vmem_addr_gen #(.VLEN(VLEN), .AW(AW), .EW(EW)) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .advance (advance),
    .base    (sreg_rdata_a),
    .step    (se_q ? sreg_rdata_b : AW'(1)),
    .addr    (addr),
    .elem    (elem),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      rw_q   <= RW_LOAD;
      se_q   <= 1'b0;
      me_q   <= 1'b0;
      vx_q   <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
      mask_q <= '1;
    end else begin
      state <= nstate;
      if (state == S_IDLE && start) begin
        rw_q <= rw;
        se_q <= stride_enable;
        me_q <= mask_enable;
        vx_q <= vx_select;
        rx_q <= rx_select;
        ry_q <= ry_select;
      end
      if (state == S_SETUP)
        mask_q <= (me_q && MASK_FEATURE) ? mask : '1;
    end
  end

  assign elem_en = mask_q[elem];

  // Masked-off elements still consume a cycle and advance the address.
  always_comb begin
    nstate  = state;
    init    = 1'b0;
    advance = 1'b0;
    done    = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    vreg_we = 1'b0;
    case (state)
      S_IDLE:  if (start) nstate = S_SETUP;
      S_SETUP: begin
        init   = 1'b1;
        nstate = S_ACCESS;
      end
      S_ACCESS: begin
        if (elem_en && rw_q == RW_LOAD) begin
          mem_re = 1'b1;
          nstate = S_WB;
        end else begin
          mem_we  = elem_en && (rw_q == RW_STORE);
          advance = 1'b1;
          nstate  = last ? S_FIN : S_ACCESS;
        end
      end
      S_WB: begin
        vreg_we = 1'b1;
        advance = 1'b1;
        nstate  = last ? S_FIN : S_ACCESS;
      end
      S_FIN: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign sreg_raddr_a   = rx_q;
  assign sreg_raddr_b   = ry_q;
  assign bus.vreg_idx   = vx_q;
  assign bus.vreg_elem  = elem;
  assign bus.vreg_we    = vreg_we;
  assign bus.vreg_wdata = vreg_we ? bus.mem_rdata : '0;
  assign bus.mem_addr   = addr;
  assign bus.mem_re     = mem_re;
  assign bus.mem_we     = mem_we;
  assign bus.mem_wdata  = mem_we ? bus.vreg_rdata : '0;

endmodule

// File: tb/tb_vmem_seq.sv
// Directed bench for vmem_seq: memory, vector RF and scalar RF models around the DUT.
module tb_vmem_seq;

  logic       clk = 1'b0;
  logic       reset, start, rw, stride_enable, mask_enable;
  logic [2:0] vx_select, rx_select, ry_select, sreg_raddr_a, sreg_raddr_b;
  logic [7:0] sreg_rdata_a, sreg_rdata_b, mask;
  logic       busy, done;

  logic [7:0] mem  [256];
  logic [7:0] vreg [64];
  logic [7:0] sreg [8];
  logic [7:0] mem_rdata_r;

  logic       pl_mem_we, pl_vreg_we;
  logic [7:0] pl_mem_addr, pl_data;
  logic [5:0] pl_vreg_addr;

  int nassert = 0;
  int nfail   = 0;
  int lat, nlog, nmulti;
  logic [7:0] addr_log [32];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  vmem_seq_if #(.VLEN(8), .DW(8), .AW(8)) bus ();

  vmem_seq #(.VLEN(8), .DW(8), .AW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rw            (rw),
    .stride_enable (stride_enable),
    .mask_enable   (mask_enable),
    .vx_select     (vx_select),
    .rx_select     (rx_select),
    .ry_select     (ry_select),
    .sreg_raddr_a  (sreg_raddr_a),
    .sreg_raddr_b  (sreg_raddr_b),
    .sreg_rdata_a  (sreg_rdata_a),
    .sreg_rdata_b  (sreg_rdata_b),
    .mask          (mask),
    .busy          (busy),
    .done          (done),
    .bus           (bus.master)
  );

  assign sreg_rdata_a   = sreg[sreg_raddr_a];
  assign sreg_rdata_b   = sreg[sreg_raddr_b];
  assign bus.vreg_rdata = vreg[{bus.vreg_idx, bus.vreg_elem}];
  assign bus.mem_rdata  = mem_rdata_r;

  always @(posedge clk) begin
    if (pl_mem_we) mem[pl_mem_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) mem_rdata_r <= mem[bus.mem_addr];
    if (pl_vreg_we) vreg[pl_vreg_addr] <= pl_data;
    else if (bus.vreg_we) vreg[{bus.vreg_idx, bus.vreg_elem}] <= bus.vreg_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nassert++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic poke_mem(input logic [7:0] a, input logic [7:0] d);
    pl_mem_we = 1'b1; pl_mem_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_mem_we = 1'b0;
  endtask

  task automatic poke_vreg(input logic [5:0] a, input logic [7:0] d);
    pl_vreg_we = 1'b1; pl_vreg_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_vreg_we = 1'b0;
  endtask

  // Issues one operation; lat = edges from the start-sampling edge to the edge that samples done.
  task automatic run_op(input logic r, input logic se, input logic me, input logic [2:0] vx,
                        input logic [2:0] rx, input logic [2:0] ry, input logic [7:0] m,
                        input int extra_start_at, input bit fin_start);
    bit found = 0;
    @(posedge clk); #1;
    rw = r; stride_enable = se; mask_enable = me;
    vx_select = vx; rx_select = rx; ry_select = ry; mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; nlog = 0; nmulti = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(posedge clk); #1;
      start = (k == extra_start_at);
      if (bus.mem_we || bus.mem_re) begin
        addr_log[nlog] = bus.mem_addr;
        nlog++;
      end
      if ((32'(bus.mem_we) + 32'(bus.mem_re) + 32'(bus.vreg_we)) > 1) nmulti++;
      if (done) begin
        found = 1;
        lat = k + 1;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(found), 32'd1);
    check("strobe_exclusive", nmulti, 0);
    if (fin_start && found) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; stride_enable = 1'b0; mask_enable = 1'b0;
    vx_select = '0; rx_select = '0; ry_select = '0; mask = '0;
    pl_mem_we = 1'b0; pl_vreg_we = 1'b0; pl_mem_addr = '0; pl_vreg_addr = '0; pl_data = '0;
    sreg[0] = 8'h00; sreg[1] = 8'h00; sreg[2] = 8'h10; sreg[3] = 8'h77;
    sreg[4] = 8'h20; sreg[5] = 8'h03; sreg[6] = 8'h40; sreg[7] = 8'hFE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {bus.mem_re, bus.mem_we, bus.vreg_we}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_vreg_elem", bus.vreg_elem, 0);
    check("rst_wdata", {bus.mem_wdata, bus.vreg_wdata}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) poke_vreg(6'(8 + i), 8'(i + 1));
    for (int i = 0; i < 8; i++) poke_mem(8'(8'h20 + 3 * i), 8'(8'hA0 + i));
    for (int i = 0; i < 8; i++) poke_mem(8'(8'h40 + i), 8'(8'h50 + i));
    for (int i = 0; i < 8; i++) poke_vreg(6'(32 + i), 8'hEE);

    // unit-stride store, vx=1, base 0x10
    run_op(1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 8'h00, 0, 0);
    check("store_latency", lat, 10);
    check("store_count", nlog, 8);
    for (int i = 0; i < 8; i++) begin
      check("store_addr", addr_log[i], 32'(8'h10 + i));
      check("store_mem", mem[8'h10 + i], 32'(i + 1));
    end

    // strided load, base 0x20 stride 3 -> vx=3
    run_op(1'b0, 1'b1, 1'b0, 3'd3, 3'd4, 3'd5, 8'h00, 0, 0);
    check("sload_latency", lat, 18);
    check("sload_count", nlog, 8);
    for (int i = 0; i < 8; i++) begin
      check("sload_addr", addr_log[i], 32'(8'h20 + 3 * i));
      check("sload_vreg", vreg[24 + i], 32'(8'hA0 + i));
    end

    // masked load 0b1010_0101 into vx=4 (preset 0xEE)
    run_op(1'b0, 1'b0, 1'b1, 3'd4, 3'd6, 3'd0, 8'hA5, 0, 0);
`ifdef VMEM_MASK_EN
    check("mload_latency", lat, 14);
    check("mload_count", nlog, 4);
    for (int i = 0; i < 8; i++) begin
      exp_v = (i == 0 || i == 2 || i == 5 || i == 7) ? 8'(8'h50 + i) : 8'hEE;
      check("mload_vreg", vreg[32 + i], 32'(exp_v));
    end
`else
    check("mload_latency", lat, 18);
    check("mload_count", nlog, 8);
    for (int i = 0; i < 8; i++) check("mload_vreg", vreg[32 + i], 32'(8'h50 + i));
`endif

    // wrap-around store, base 0xFE stride 1
    run_op(1'b1, 1'b0, 1'b0, 3'd1, 3'd7, 3'd0, 8'h00, 0, 0);
    check("wrap_latency", lat, 10);
    for (int i = 0; i < 8; i++) begin
      check("wrap_addr", addr_log[i], 32'(8'(8'hFE + i)));
      check("wrap_mem", mem[8'(8'hFE + i)], 32'(i + 1));
    end

    // start while busy and start during FIN are both ignored
    run_op(1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00, 4, 1);
    check("busy_start_latency", lat, 10);
    check("fin_start_ignored", busy, 0);
    expect_no_done("single_done", 15);

    // reset during element 3 of a load
    @(posedge clk); #1;
    rw = 1'b0; stride_enable = 1'b0; mask_enable = 1'b0;
    vx_select = 3'd5; rx_select = 3'd2; ry_select = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !(bus.mem_re && bus.vreg_elem == 3'd3); k++) begin
      @(posedge clk); #1;
      lat++;
    end
    check("reach_elem3", {bus.mem_re, bus.vreg_elem}, {1'b1, 3'd3});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_strobes", {bus.mem_re, bus.mem_we, bus.vreg_we}, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", bus.mem_addr, 0);
    check("rst_mid_elem", bus.vreg_elem, 0);
    expect_no_done("rst_mid_no_done", 20);

    run_op(1'b0, 1'b0, 1'b0, 3'd5, 3'd2, 3'd0, 8'h00, 0, 0);
    check("post_rst_latency", lat, 18);
    for (int i = 0; i < 8; i++) check("post_rst_vreg", vreg[40 + i], 32'(i + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/vmem_seq.md
VMEM_SEQ -- requirements
Module: vmem_seq

Interface
REQ-001 Parameters SHALL be: VLEN, 8, elements per vector (power of two, ≥2); DW, 8, element/data width; AW, 8, memory address width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request pulse from instruction decoder
- rw  in  1  0 = vector load, 1 = vector store
- stride_enable  in  1  strided addressing
- mask_enable  in  1  masked access
- vx_select  in  3  target/source vector register
- rx_select  in  3  scalar register holding base address
- ry_select  in  3  scalar register holding stride
- sreg_raddr_a  out  3  scalar RF read address A (= rx_select)
- sreg_raddr_b  out  3  scalar RF read address B (= ry_select)
- sreg_rdata_a  in  AW  base address (combinational read)
- sreg_rdata_b  in  AW  stride (combinational read)
- mask  in  VLEN  element mask; bit i enables element i
- vreg_idx  out  3  vector RF register index
- vreg_elem  out  log2(VLEN)  vector RF element index
- vreg_we  out  1  vector RF write enable
- vreg_wdata  out  DW  vector RF write data
- vreg_rdata  in  DW  vector RF read data (combinational)
- mem_addr  out  AW  memory address
- mem_re  out  1  memory read strobe; data valid next cycle
- mem_we  out  1  memory write strobe
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse

Function
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS, WB, FIN.
REQ-005 IDLE: start=1 -> SETUP; rw, stride_enable, mask_enable, vx_select, rx_select, ry_select latched; start SHALL be ignored in every other state.
REQ-006 SETUP: base <- sreg_rdata_a; step <- stride_enable ? sreg_rdata_b : 1; mask latched (all-ones if mask_enable=0); element index i <- 0; -> ACCESS.
REQ-007 Address of element i SHALL be (base + i*step) mod 2^AW, computed incrementally; wrap-around SHALL NOT be flagged.
REQ-008 ACCESS, element enabled, store: mem_we=1, mem_addr=addr, vreg_elem=i, mem_wdata=vreg_rdata for one cycle.
REQ-009 ACCESS, element enabled, load: mem_re=1 for one cycle, then WB: vreg_we=1, vreg_wdata=mem_rdata, vreg_elem=i.
REQ-010 ACCESS, element masked off: no strobe asserted; one cycle consumed; address still advances.
REQ-011 After element VLEN-1 -> FIN; otherwise i increments and the FSM stays in or returns to ACCESS.
REQ-012 FIN: done=1 for exactly one cycle -> IDLE.
REQ-013 Latency from start sample: store = 2+VLEN cycles to done; load = 2+VLEN+(enabled elements) cycles; all-masked = 2+VLEN.
REQ-014 vreg_idx SHALL equal latched vx_select; mem_re, mem_we and vreg_we SHALL never be asserted together.
REQ-015 start in the same cycle as FIN SHALL be ignored; requester re-issues after done.

Reset
REQ-016 reset=1 SHALL force IDLE; clear busy, done, mem_re, mem_we, vreg_we; zero mem_addr, mem_wdata, vreg_wdata, vreg_elem, i; effective on the same edge, including mid-operation (no done issued).

Configuration
REQ-017 With VMEM_MASK_EN defined, masking SHALL follow REQ-006/010; without it, mask_enable and mask SHALL be ignored and every element accessed (ports retained).

Structure
REQ-018 Package vp_pkg SHALL hold the FSM state enum, VLEN/DW/AW defaults and the rw encodings.
REQ-019 Sub-module vmem_addr_gen SHALL hold the base/step/address accumulator and element counter.

Verification
REQ-020 Unit-stride store: base=0x10, vreg elems 1..8 -> mem[0x10..0x17]=1..8; done at cycle 10.
REQ-021 Strided load: base=0x20, stride=3 -> reads 0x20,0x23,…,0x35 into vx elems 0..7; done at cycle 18.
REQ-022 Masked load mask=0b1010_0101 -> only elems 0,2,5,7 written; done at cycle 14; without VMEM_MASK_EN all 8 written.
REQ-023 Wrap: base=0xFE, stride=1 store -> addresses 0xFE,0xFF,0x00..0x05.
REQ-024 Reset asserted at element 3 of a load -> strobes low on the next edge, no done, IDLE; a following start runs normally.
REQ-025 start pulsed while busy -> ignored; exactly one done per accepted start.
